// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared phase type, 640x480 defaults and counter width for the VGA raster
package vga_timing_pkg;

  // Phase of one raster axis; both axes walk ACTIVE -> FRONT -> PULSE -> BACK
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_PULSE  = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 18;
  localparam int H_PULSE_DEF  = 92;
  localparam int H_BACK_DEF   = 50;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_PULSE_DEF  = 2;
  localparam int V_BACK_DEF   = 33;

  localparam int CNT_W = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter, phase FSM and wrap pulse
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SEG_ACTIVE = H_ACTIVE_DEF,
  parameter int SEG_FRONT  = H_FRONT_DEF,
  parameter int SEG_PULSE  = H_PULSE_DEF,
  parameter int SEG_BACK   = H_BACK_DEF
) (
  input  logic             CLK,
  input  logic             i_Reset,
  input  logic             advance,
  output logic [CNT_W-1:0] pos,
  output phase_t           phase,
  output logic             wrap
);

  localparam int TOTAL = SEG_ACTIVE + SEG_FRONT + SEG_PULSE + SEG_BACK;

  if (SEG_ACTIVE < 1 || SEG_FRONT < 1 || SEG_PULSE < 1 || SEG_BACK < 1 ||
      TOTAL > (1 << CNT_W)) begin : g_param_err
    $error("vga_axis_counter: segment lengths must be >= 1 and total <= 1024");
  end

  // Last position of each segment; the phase moves on when pos sits on one of these
  localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(SEG_ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(SEG_ACTIVE + SEG_FRONT - 1);
  localparam logic [CNT_W-1:0] END_PULSE  = CNT_W'(SEG_ACTIVE + SEG_FRONT + SEG_PULSE - 1);
  localparam logic [CNT_W-1:0] END_BACK   = CNT_W'(TOTAL - 1);

  // Wrap is qualified by advance so it can directly clock the next axis
  assign wrap = advance && (pos == END_BACK);

  // Position and phase step together so phase always describes the current pos
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      pos   <= '0;
      phase <= PH_ACTIVE;
    end else if (advance) begin
      pos <= (pos == END_BACK) ? '0 : pos + 1'b1;
      case (phase)
        PH_ACTIVE: if (pos == END_ACTIVE) phase <= PH_FRONT;
        PH_FRONT:  if (pos == END_FRONT)  phase <= PH_PULSE;
        PH_PULSE:  if (pos == END_PULSE)  phase <= PH_BACK;
        PH_BACK:   if (pos == END_BACK)   phase <= PH_ACTIVE;
        default:   phase <= PH_ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_controller.sv
// rtl/vga_timing_controller.sv - VGA raster sequencer; VGA_PREFETCH_EN adds next-pixel fetch outputs
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_PULSE  = H_PULSE_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_PULSE  = V_PULSE_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic             CLK,
  input  logic             i_Reset,
  input  logic             i_Enable,
  output logic             o_H_Sync,
  output logic             o_V_Sync,
  output logic             o_Active,
  output logic [CNT_W-1:0] o_Col,
  output logic [CNT_W-1:0] o_Row,
  output logic             o_Line_Start,
  output logic             o_Frame_Start
`ifdef VGA_PREFETCH_EN
  ,
  output logic             o_Fetch_Req,
  output logic [CNT_W-1:0] o_Fetch_Col,
  output logic [CNT_W-1:0] o_Fetch_Row
`endif
);

  logic [CNT_W-1:0] h_pos, v_pos;
  phase_t           h_phase, v_phase;
  logic             h_wrap, v_wrap;

  vga_axis_counter #(
    .SEG_ACTIVE(H_ACTIVE), .SEG_FRONT(H_FRONT), .SEG_PULSE(H_PULSE), .SEG_BACK(H_BACK)
  ) u_h (
    .CLK(CLK), .i_Reset(i_Reset), .advance(i_Enable),
    .pos(h_pos), .phase(h_phase), .wrap(h_wrap)
  );

  // The vertical axis only moves when a line completes
  vga_axis_counter #(
    .SEG_ACTIVE(V_ACTIVE), .SEG_FRONT(V_FRONT), .SEG_PULSE(V_PULSE), .SEG_BACK(V_BACK)
  ) u_v (
    .CLK(CLK), .i_Reset(i_Reset), .advance(h_wrap),
    .pos(v_pos), .phase(v_phase), .wrap(v_wrap)
  );

  // Register the decode of the current position; everything freezes while disabled
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      o_H_Sync      <= 1'b1;
      o_V_Sync      <= 1'b1;
      o_Active      <= 1'b0;
      o_Col         <= '0;
      o_Row         <= '0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else if (i_Enable) begin
      o_H_Sync      <= (h_phase != PH_PULSE);
      o_V_Sync      <= (v_phase != PH_PULSE);
      o_Active      <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      o_Col         <= h_pos;
      o_Row         <= v_pos;
      o_Line_Start  <= (h_pos == '0);
      o_Frame_Start <= (h_pos == '0) && (v_pos == '0);
    end
  end

`ifdef VGA_PREFETCH_EN
  localparam logic [CNT_W-1:0] H_ACT_W = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_W = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] nxt_h, nxt_v;

  // Position the counters will hold after this edge (wraps already include enable)
  always_comb begin
    nxt_h = h_wrap ? '0 : h_pos + 1'b1;
    nxt_v = v_wrap ? '0 : (h_wrap ? v_pos + 1'b1 : v_pos);
  end

  // Fetch outputs lead o_Active/o_Col/o_Row by exactly one enabled edge
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      o_Fetch_Req <= 1'b0;
      o_Fetch_Col <= '0;
      o_Fetch_Row <= '0;
    end else if (i_Enable) begin
      o_Fetch_Req <= (nxt_h < H_ACT_W) && (nxt_v < V_ACT_W);
      o_Fetch_Col <= nxt_h;
      o_Fetch_Row <= nxt_v;
    end
  end
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb/tb_vga_timing_controller.sv - scoreboard bench for vga_timing_controller with a short frame
module tb_vga_timing_controller;

  // Full 640-wide lines, but only 13 lines per frame so whole frames fit in a short run
  localparam int HA = 640, HF = 18, HP = 92, HB = 50;
  localparam int VA = 6, VF = 2, VP = 2, VB = 3;
  localparam int HT = 800, VT = 13;
  localparam int FRAME_EDGES = 10400;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic hs, vs, act, ls, fs;
  logic [9:0] col, row;
`ifdef VGA_PREFETCH_EN
  logic freq;
  logic [9:0] fcol, frow;
`endif

  vga_timing_controller #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB)
  ) dut (
    .CLK(clk), .i_Reset(rst), .i_Enable(en),
    .o_H_Sync(hs), .o_V_Sync(vs), .o_Active(act),
    .o_Col(col), .o_Row(row), .o_Line_Start(ls), .o_Frame_Start(fs)
`ifdef VGA_PREFETCH_EN
    , .o_Fetch_Req(freq), .o_Fetch_Col(fcol), .o_Fetch_Row(frow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic hs, vs, act, ls, fs;
    logic [9:0] col, row;
    logic freq;
    logic [9:0] fcol, frow;
  } vec_t;

  vec_t q[$];
  vec_t held;
  int n_cmp = 0, n_bad = 0;
  int m_col = 0, m_row = 0;
  int edges = 0;
  int fs_mark = -1, vlow_cnt = 0, hlow_cnt = 0, act_cnt = 0;
  logic vlow_ok = 1'b0, line_ok = 1'b0, prev_vs = 1'b1;

  function automatic vec_t reset_vec();
    vec_t v = '0;
    v.hs = 1'b1;
    v.vs = 1'b1;
    return v;
  endfunction

  function automatic vec_t observed();
    vec_t v = '0;
    v.hs = hs; v.vs = vs; v.act = act; v.ls = ls; v.fs = fs;
    v.col = col; v.row = row;
`ifdef VGA_PREFETCH_EN
    v.freq = freq; v.fcol = fcol; v.frow = frow;
`endif
    return v;
  endfunction

  task automatic check(input string nm, input vec_t got, input vec_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got col=%0d row=%0d hs=%b vs=%b act=%b ls=%b fs=%b fetch=%b/%0d/%0d want col=%0d row=%0d hs=%b vs=%b act=%b ls=%b fs=%b fetch=%b/%0d/%0d",
               nm, $time, got.col, got.row, got.hs, got.vs, got.act, got.ls, got.fs, got.freq, got.fcol, got.frow,
               want.col, want.row, want.hs, want.vs, want.act, want.ls, want.fs, want.freq, want.fcol, want.frow);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, got, want);
    end
  endtask

  // Expected outputs for a pixel at (c, r), from the timing table arithmetic
  function automatic vec_t model_vec(input int c, input int r, input int nc, input int nr);
    vec_t v = '0;
    v.col = 10'(c);
    v.row = 10'(r);
    v.hs  = !(c >= HA + HF && c < HA + HF + HP);
    v.vs  = !(r >= VA + VF && r < VA + VF + VP);
    v.act = (c < HA) && (r < VA);
    v.ls  = (c == 0);
    v.fs  = (c == 0) && (r == 0);
`ifdef VGA_PREFETCH_EN
    v.freq = (nc < HA) && (nr < VA);
    v.fcol = 10'(nc);
    v.frow = 10'(nr);
`else
    if (nc < 0 || nr < 0) v.freq = 1'b0;
`endif
    return v;
  endfunction

  task automatic step(input logic e);
    int nc, nr;
    @(negedge clk);
    en = e;
    if (e) begin
      nc = m_col + 1;
      nr = m_row;
      if (nc == HT) begin
        nc = 0;
        nr = (m_row + 1 == VT) ? 0 : m_row + 1;
      end
      q.push_back(model_vec(m_col, m_row, nc, nr));
      m_col = nc;
      m_row = nr;
    end
  endtask

  task automatic clear_tracking();
    m_col = 0; m_row = 0;
    fs_mark = -1; vlow_ok = 1'b0; line_ok = 1'b0; prev_vs = 1'b1;
    held = reset_vec();
  endtask

  // Monitor: pops one expected vector per enabled edge, otherwise expects outputs frozen
  logic mon_en;
  vec_t o;
  always @(posedge clk) begin
    if (!rst) begin
      mon_en = en;
      #1;
      o = observed();
      if (!mon_en) begin
        check("hold", o, held);
      end else if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty @%0t: got enabled edge, want a queued vector", $time);
      end else begin
        held = q.pop_front();
        check("edge", o, held);
        edges++;
        if (o.ls) begin
          hlow_cnt = 0; act_cnt = 0; line_ok = 1'b1;
        end
        hlow_cnt += int'(!o.hs);
        act_cnt  += int'(o.act);
        if (o.col == 10'(HT - 1) && line_ok) begin
          chk_int("hsync_low_width", hlow_cnt, HP);
          chk_int("active_width", act_cnt, (o.row < 10'(VA)) ? HA : 0);
          line_ok = 1'b0;
        end
        if (o.fs) begin
          if (fs_mark >= 0) chk_int("frame_period", edges - fs_mark, FRAME_EDGES);
          if (vlow_ok) chk_int("vsync_low_width", vlow_cnt, VP * HT);
          fs_mark = edges; vlow_cnt = 0; vlow_ok = 1'b1;
        end
        vlow_cnt += int'(!o.vs);
        if (prev_vs && !o.vs) begin
          chk_int("vsync_fall_col", int'(o.col), 0);
          chk_int("vsync_fall_row", int'(o.row), VA + VF);
        end
        prev_vs = o.vs;
      end
    end
  end

  initial begin
    int got;
    logic b;
    clear_tracking();
    #1 rst = 1'b1;
    #1 check("reset_state", observed(), reset_vec());
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) step(1'b0);
    @(negedge clk);
    check("idle_after_reset", observed(), reset_vec());

    repeat (FRAME_EDGES + 2 * HT) step(1'b1);

    got = 0;
    while (got < FRAME_EDGES) begin
      b = 1'(int'($urandom_range(0, 1)));
      step(b);
      got += int'(b);
    end
    repeat (HT) step(1'b1);

    for (int i = 0; i < 2 * FRAME_EDGES && !(m_row == 4 && m_col == 401); i++) step(1'b1);
    if (!(m_row == 4 && m_col == 401)) begin
      n_cmp++; n_bad++;
      $display("FAIL reach_row4_col400: got row=%0d col=%0d want row=4 col=401", m_row, m_col);
    end
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1 check("reset_midframe", observed(), reset_vec());
    clear_tracking();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (HT + 5) step(1'b1);
    repeat (3) step(1'b0);
    @(negedge clk);
    chk_int("scoreboard_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Master raster sequencer for the 640x480 VGA output path. It owns the horizontal and vertical position counters and steps each axis through its active, front-porch, sync-pulse and back-porch phases. From that state it drives the final active-low H/V sync outputs, the active-video qualifier, pixel coordinates, and line/frame strobes. Downstream pixel generators and the DAC/pin stage take their timing from this block; nothing else in the video path counts.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 18, horizontal front porch (clocks)
- H_PULSE, 92, horizontal sync pulse (clocks)
- H_BACK, 50, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_PULSE, 2, vertical sync pulse (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK  input  1  pixel clock; all state on rising edge
- i_Reset  input  1  asynchronous, active-high reset
- i_Enable  input  1  advance raster by one pixel on this edge; 0 = freeze all state
- o_H_Sync  output  1  horizontal sync, active low
- o_V_Sync  output  1  vertical sync, active low
- o_Active  output  1  current pixel is in the visible area
- o_Col  output  10  current horizontal position, 0..H_TOTAL-1
- o_Row  output  10  current vertical position, 0..V_TOTAL-1
- o_Line_Start  output  1  pulse: o_Col == 0
- o_Frame_Start  output  1  pulse: o_Col == 0 and o_Row == 0

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Each segment must be ≥1. Each total must be ≤1024. Violations are a parameter error (elaboration-time check).
- Internal next-position counters h_pos/v_pos reset to 0. On each enabled edge:
  - the outputs register the decode of (h_pos, v_pos);
  - h_pos then increments.
- h_pos wrap: H_TOTAL-1 → 0, and v_pos increments on the same edge. v_pos wraps V_TOTAL-1 → 0.
- Per-axis FSM: ACTIVE → FRONT → PULSE → BACK → ACTIVE. Transitions occur at segment boundaries.
  - Horizontal phases: cols 0-639 ACTIVE, 640-657 FRONT, 658-749 PULSE, 750-799 BACK.
  - Vertical phases: rows 0-479 ACTIVE, 480-489 FRONT, 490-491 PULSE, 492-524 BACK.
  - The vertical FSM advances only on horizontal wrap.
- Output decode:
  - o_H_Sync = 0 iff the horizontal phase is PULSE.
  - o_V_Sync = 0 iff the vertical phase is PULSE. It changes only at col 0.
  - o_Active = horizontal ACTIVE AND vertical ACTIVE.
- o_Col/o_Row report raw position, including blanking.
- i_Enable = 0 holds all counters, FSMs and outputs. Strobes stay at their held value, so a 1 can persist while enable is low. Consumers qualify strobes with enable.

## Timing
- Reset values: o_H_Sync=1, o_V_Sync=1, o_Active=0, o_Col=0, o_Row=0, o_Line_Start=0, o_Frame_Start=0; h_pos=v_pos=0; both FSMs in ACTIVE.
- Reset asserted mid-frame forces these values immediately (asynchronously). Release is synchronised by the user.
- Latency: the first enabled edge after reset presents (0,0) with o_Active=1 and both strobes high.
- Line period: 800 enabled edges. Frame period: 420000 enabled edges.
- All outputs are registered; no combinational path from any input to any output.
- Simultaneous h and v wrap (799,524 → 0,0): single edge. o_Row goes to 0 on that edge and o_Frame_Start asserts.

## Configuration
- VGA_PREFETCH_EN defined: adds three outputs.
  - o_Fetch_Req (1): high when the next enabled edge will present an active pixel.
  - o_Fetch_Col (10) and o_Fetch_Row (10): the coordinates of that pixel.
  - Purpose: a one-cycle-latency pixel memory lands in step with o_Active.
  - All three reset to 0 and hold while i_Enable=0.
- Undefined: these ports and their logic are absent.

## Structure
- Package vga_timing_pkg holds:
  - the axis phase enum (ACTIVE, FRONT, PULSE, BACK);
  - the 640x480 default constants;
  - the counter width constant (10).
- Sub-module vga_axis_counter, instantiated twice (horizontal, vertical):
  - parameters: four segment lengths;
  - inputs: CLK, i_Reset, advance;
  - outputs: position, phase, wrap pulse.
  - The horizontal wrap output drives the vertical advance.

## Test plan
- Reset, then hold i_Enable=0 for 10 cycles → all outputs at reset values, o_Col=0.
- Enable continuously; track line 0 → o_Active high for 640 edges; o_H_Sync low exactly cols 658-749 (92 edges); o_Line_Start high only at col 0.
- Run one full frame → o_Frame_Start pulses spaced by 420000 edges; o_V_Sync low for rows 490-491 (1600 edges), falling at col 0 of row 490.
- Toggle i_Enable with a 50% random pattern for one frame → outputs follow the gated count exactly; frame still 420000 enabled edges.
- Assert i_Reset at row 300, col 400 → outputs return to reset values without a clock; after release, first enabled edge presents (0,0).
- With VGA_PREFETCH_EN → on every edge, o_Fetch_Req/o_Fetch_Col/o_Fetch_Row equal o_Active/o_Col/o_Row sampled one enabled edge later, including at the 799,524 → 0,0 wrap.
